game_ctrl: RTL
==============

// Module: game_ctrl
// PURPOSE
//  Game sequencer for Breakout. Sits between the switches, move_ball/move_bar and placar.
//  Starts, serves, runs and ends a match:
//   - gates ball motion (ball_en);
//   - recentres ball and bar (ball_reload);
//   - tracks remaining lives;
//   - raises ball speed every HITS_PER_LEVEL bar hits (acceleration);
//   - clears the current score on every new game.
// PARAMETERS
//  LIVES           3   lives per game (1..7)
//  SERVE_FRAMES    60  frame ticks the ball stays parked before each serve (>=1)
//  HITS_PER_LEVEL  5   bar hits per speed increment (>=1)
//  MAX_SPEED       8   speed ceiling (1..15)
// PORTS
//  clock        in   1  VGA pixel clock; the only clock
//  reset        in   1  asynchronous, active-low reset
//  start        in   1  start switch level; asynchronous, synchronised inside
//  frame_tick   in   1  1-cycle pulse per video frame, from vga
//  hit_bar      in   1  ball touched bar, from move_ball (level or pulse)
//  endgame      in   1  ball passed the bar, from move_ball (level or pulse)
//  ball_en      out  1  1 = move_ball may advance the ball
//  ball_reload  out  1  1 = move_ball/move_bar hold their centre positions
//  speed        out  4  ball step in pixels per frame, 1..MAX_SPEED
//  lives        out  3  remaining lives
//  score_clear  out  1  1-cycle pulse: placar resets its current score
//  game_over    out  1  1 while in GAMEOVER
//  state        out  2  IDLE=0, SERVE=1, PLAY=2, GAMEOVER=3 (debug/LEDs)
// BEHAVIOUR
//  Reset values (async, while reset=0):
//   - state=IDLE, ball_en=0, ball_reload=1, speed=1, lives=0, score_clear=0, game_over=0.
//   - All counters and sync flops are cleared.
//  Input conditioning:
//   - start: 2-flop synchroniser, then rising-edge detect.
//   - hit_bar, endgame: rising-edge detect only; a held level counts once.
//   - Latency: a start edge changes state 3 cycles after start rises.
//   - Latency: a hit_bar/endgame edge takes effect on the next clock edge.
//  Start edge (any state, including SERVE/PLAY) = new game:
//   - state<=SERVE, lives<=LIVES, speed<=1, hit_cnt<=0, serve_cnt<=0.
//   - score_clear pulses in the same cycle as the state change.
//  IDLE:
//   - ball_en=0, ball_reload=1.
//   - Leaves only on a start edge.
//  SERVE:
//   - ball_en=0, ball_reload=1.
//   - serve_cnt counts frame_tick.
//   - On the tick where serve_cnt==SERVE_FRAMES-1: state<=PLAY, serve_cnt<=0.
//   - hit_bar and endgame are ignored.
//  PLAY:
//   - ball_en=1, ball_reload=0.
//   - hit edge: hit_cnt+1. If hit_cnt==HITS_PER_LEVEL-1, hit_cnt<=0 and
//     speed<=min(speed+1, MAX_SPEED). At MAX_SPEED speed saturates; it never wraps.
//   - endgame edge, lives>1: lives-1, state<=SERVE; speed and hit_cnt are kept.
//   - endgame edge, lives==1: lives<=0, state<=GAMEOVER.
//   - Simultaneous hit and endgame edges: endgame wins; the hit is discarded.
//  GAMEOVER:
//   - ball_en=0, ball_reload=0 (ball frozen where it died), game_over=1.
//   - Leaves only on a start edge.
//  Precedence and widths:
//   - A start edge overrides every other event in the same cycle.
//   - serve_cnt is wide enough for SERVE_FRAMES, e.g. $clog2(SERVE_FRAMES+1).
//   - hit_cnt is wide enough for HITS_PER_LEVEL.
//   - All comparisons are unsigned.
//   - The serve countdown is frame-based, so it is independent of clock frequency.
// STRUCTURE
//  - Shared include breakout_defs.vh holds:
//    - state encodings (ST_IDLE..ST_GAMEOVER);
//    - speed width (4) and lives width (3);
//    - R_BALL/W_BAR/H_BAR, so move_ball and top share one copy.
//  - One sub-module, edge_sync: N-flop synchroniser plus rising-edge pulse, used for start.
//    hit_bar and endgame need only the edge detector (same clock domain).
//  - The FSM, the serve counter and the hit/speed counter live in game_ctrl.
// TESTING
//  1. Reset low for 5 cycles, then release:
//     expect state=0, ball_reload=1, ball_en=0, speed=1, lives=0.
//  2. Raise start (defaults):
//     - 3 cycles later: state=SERVE, lives=3, one score_clear pulse.
//     - After 60 frame_ticks: state=PLAY, ball_en=1.
//  3. In PLAY, 10 hit_bar pulses:
//     - speed=3 after hit 10.
//     - With MAX_SPEED=2, speed stops at 2.
//     - hit_bar held high for 100 cycles counts one hit.
//  4. Three endgame edges, each after a completed serve:
//     - lives 3->2->1, back in SERVE each time.
//     - Third edge: GAMEOVER, game_over=1, ball_en=0.
//  5. hit_bar and endgame rise in the same cycle:
//     lives decrements, hit_cnt and speed unchanged.
//  6. Stimulus mid-operation:
//     - Start edge during PLAY: restarts to SERVE, lives=3, speed=1, score_clear.
//     - Reset pulse mid-SERVE: IDLE immediately, asynchronously.

Source files
------------

// File: rtl/game_ctrl_pkg.sv
// Shared Breakout types: FSM state encoding, speed and lives widths, speed step helper.
// No logic of its own; imported by the sequencer.
// Holds nothing that could stall or backpressure anything.
package game_ctrl_pkg;

    localparam int SPEED_W = 4;
    localparam int LIVES_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SERVE    = 2'd1,
        ST_PLAY     = 2'd2,
        ST_GAMEOVER = 2'd3
    } state_e;

    // One speed level up, pinned at the ceiling so it can never wrap.
    function automatic logic [SPEED_W-1:0] speed_step(input logic [SPEED_W-1:0] cur,
                                                      input logic [SPEED_W-1:0] ceil);
        return (cur < ceil) ? cur + 1'b1 : ceil;
    endfunction

endpackage

// File: rtl/game_ctrl_edge_sync.sv
// Optional N-flop synchroniser followed by a rising-edge detector (1-cycle pulse).
// Latency: STAGES cycles to the synchronised level; the pulse is combinational from that level.
// No backpressure; a held level produces exactly one pulse.
module game_ctrl_edge_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic pulse_o
);

    logic level;
    logic prev_q;

    generate
        if (STAGES == 0) begin : g_direct
            assign level = d_i;
        end else begin : g_sync
            logic [STAGES-1:0] sync_q;

            // Shift the asynchronous input through the synchroniser chain.
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    sync_q <= '0;
                end else begin
                    sync_q[0] <= d_i;
                    for (int i = 1; i < int'(STAGES); i++) begin
                        sync_q[i] <= sync_q[i-1];
                    end
                end
            end

            assign level = sync_q[STAGES-1];
        end
    endgenerate

    // Remember last cycle's level so only a 0->1 change fires.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= level;
        end
    end

    assign pulse_o = level & ~prev_q;

endmodule

// File: rtl/game_ctrl.sv
// Breakout match sequencer: serve/play/game-over FSM, lives, serve countdown, speed ramp.
// Latency: start acts 3 cycles after it rises; hit_bar/endgame edges act on the next clock edge.
// No backpressure; events are edge-detected and a start edge overrides everything else.
module game_ctrl
    import game_ctrl_pkg::*;
#(
    parameter int unsigned LIVES          = 3,
    parameter int unsigned SERVE_FRAMES   = 60,
    parameter int unsigned HITS_PER_LEVEL = 5,
    parameter int unsigned MAX_SPEED      = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               frame_tick,
    input  logic               hit_bar,
    input  logic               endgame,
    output logic               ball_en,
    output logic               ball_reload,
    output logic [SPEED_W-1:0] speed,
    output logic [LIVES_W-1:0] lives,
    output logic               score_clear,
    output logic               game_over,
    output logic [1:0]         state
);

    localparam int SW = $clog2(SERVE_FRAMES + 1);
    localparam int HW = $clog2(HITS_PER_LEVEL + 1);

    localparam logic [SW-1:0]      SERVE_LAST = SW'(SERVE_FRAMES - 1);
    localparam logic [HW-1:0]      HIT_LAST   = HW'(HITS_PER_LEVEL - 1);
    localparam logic [SPEED_W-1:0] SPEED_MAX  = SPEED_W'(MAX_SPEED);
    localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(LIVES);

    state_e             state_q, state_d;
    logic [LIVES_W-1:0] lives_q, lives_d;
    logic [SPEED_W-1:0] speed_q, speed_d;
    logic [SW-1:0]      serve_cnt_q, serve_cnt_d;
    logic [HW-1:0]      hit_cnt_q, hit_cnt_d;
    logic               score_clear_q, score_clear_d;

    logic start_pulse;
    logic hit_pulse;
    logic end_pulse;

    // start comes from a switch in no particular clock domain.
    game_ctrl_edge_sync #(.STAGES(2)) u_start_sync (
        .clk_i  (clock),
        .rst_ni (reset),
        .d_i    (start),
        .pulse_o(start_pulse)
    );

    // hit_bar/endgame are already in this domain; only the edge matters.
    game_ctrl_edge_sync #(.STAGES(0)) u_hit_edge (
        .clk_i  (clock),
        .rst_ni (reset),
        .d_i    (hit_bar),
        .pulse_o(hit_pulse)
    );

    game_ctrl_edge_sync #(.STAGES(0)) u_end_edge (
        .clk_i  (clock),
        .rst_ni (reset),
        .d_i    (endgame),
        .pulse_o(end_pulse)
    );

    // Next-state: a new game beats everything, then per-state events; endgame beats a hit.
    always_comb begin
        state_d       = state_q;
        lives_d       = lives_q;
        speed_d       = speed_q;
        serve_cnt_d   = serve_cnt_q;
        hit_cnt_d     = hit_cnt_q;
        score_clear_d = 1'b0;

        if (start_pulse) begin
            state_d       = ST_SERVE;
            lives_d       = LIVES_INIT;
            speed_d       = SPEED_W'(1);
            serve_cnt_d   = '0;
            hit_cnt_d     = '0;
            score_clear_d = 1'b1;
        end else begin
            case (state_q)
                ST_SERVE: begin
                    if (frame_tick) begin
                        if (serve_cnt_q == SERVE_LAST) begin
                            state_d     = ST_PLAY;
                            serve_cnt_d = '0;
                        end else begin
                            serve_cnt_d = serve_cnt_q + 1'b1;
                        end
                    end
                end
                ST_PLAY: begin
                    if (end_pulse) begin
                        if (lives_q > LIVES_W'(1)) begin
                            lives_d = lives_q - 1'b1;
                            state_d = ST_SERVE;
                        end else begin
                            lives_d = '0;
                            state_d = ST_GAMEOVER;
                        end
                    end else if (hit_pulse) begin
                        if (hit_cnt_q == HIT_LAST) begin
                            hit_cnt_d = '0;
                            speed_d   = speed_step(speed_q, SPEED_MAX);
                        end else begin
                            hit_cnt_d = hit_cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    // IDLE and GAMEOVER wait for a start edge only.
                end
            endcase
        end
    end

    // Match state registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            lives_q       <= '0;
            speed_q       <= SPEED_W'(1);
            serve_cnt_q   <= '0;
            hit_cnt_q     <= '0;
            score_clear_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            lives_q       <= lives_d;
            speed_q       <= speed_d;
            serve_cnt_q   <= serve_cnt_d;
            hit_cnt_q     <= hit_cnt_d;
            score_clear_q <= score_clear_d;
        end
    end

    // In GAMEOVER the ball stays frozen where it died rather than recentring.
    assign ball_en     = (state_q == ST_PLAY);
    assign ball_reload = (state_q == ST_IDLE) || (state_q == ST_SERVE);
    assign game_over   = (state_q == ST_GAMEOVER);
    assign speed       = speed_q;
    assign lives       = lives_q;
    assign score_clear = score_clear_q;
    assign state       = state_q;

endmodule
